// File: rtl/mac_multiplex_stream.sv
// mac_multiplex_stream
// Streaming precision-scalable SIMD MAC. The w (signed) and a (unsigned) operands
// are split into L = 2**mode lanes. The lane products are summed, and that sum is
// accumulated over acc_len samples. The group result is then presented on a
// valid/ready output.
// Pipeline: stage 1 registers the operands, stage 2 registers the lane-product
// sum, stage 3 holds the accumulator, and the FSM registers z/out_valid/ovf.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   config_aw            precision mode (clamped to MODE_NB-1), latched per group
//   acc_len              samples per group (0 acts as 1), latched per group
//   in_valid/in_ready    operand handshake
//   w, a                 packed lane operands
//   out_valid/out_ready  result handshake
//   z                    signed accumulated group result
//   ovf                  sticky signed-overflow flag for the group in z
//
// state | meaning
// IDLE  | waiting for the first sample of a group
// ACCUM | accepting the remaining samples of the group
// DRAIN | no accepts; waiting for the last sample to leave stage 3
// HOLD  | result presented, waiting for out_ready
module mac_multiplex_stream #(
   parameter int W_WIDTH         = 8,
   parameter int A_WIDTH         = 8,
   parameter int PLUS_WIDTH      = 4,
   parameter int MODE_NB         = 3,
   parameter int CONFIG_AW_WIDTH = 2,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [CONFIG_AW_WIDTH-1:0]                     config_aw,
   input  logic [CNT_WIDTH-1:0]                           acc_len,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [W_WIDTH-1:0]                             w,
   input  logic [A_WIDTH-1:0]                             a,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic signed [W_WIDTH+A_WIDTH+PLUS_WIDTH-1:0]   z,
   output logic                                           ovf
);

   localparam int Z_WIDTH = W_WIDTH + A_WIDTH + PLUS_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
   state_t state;

   logic [CNT_WIDTH-1:0]       count, len_q, len_eff;
   logic [CONFIG_AW_WIDTH-1:0] mode_q, mode_eff;
   logic                       accept, acc_first, acc_last;
   logic [W_WIDTH-1:0]         w_s1;
   logic [A_WIDTH-1:0]         a_s1;
   logic                       s1_v, s1_first, s1_last;
   logic                       s2_v, s2_first, s2_last;
   logic                       s3_last;
   logic signed [Z_WIDTH-1:0]  p_s2, acc, acc_base, acc_sum;
   logic                       acc_ovf, add_ovf;
   logic signed [Z_WIDTH-1:0]  psum [MODE_NB];

   assign in_ready  = (state == IDLE || state == ACCUM) && !rst;
   assign accept    = in_valid & in_ready;
   assign len_eff   = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
   assign mode_eff  = (int'(config_aw) >= MODE_NB) ? CONFIG_AW_WIDTH'(MODE_NB - 1) : config_aw;
   assign acc_first = (state == IDLE);
   assign acc_last  = (state == IDLE  && len_eff == CNT_WIDTH'(1)) ||
                      (state == ACCUM && count == len_q - 1'b1);

   // Stage 1: operand capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v     <= 1'b0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         w_s1     <= '0;
         a_s1     <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_first <= acc_first;
            s1_last  <= acc_last;
            w_s1     <= w;
            a_s1     <= a;
         end
      end
   end

   // One exact lane-product sum per mode. mode_q selects among them, and mode_q
   // is stable for the whole group.
   for (genvar m = 0; m < MODE_NB; m++) begin : g_mode
      localparam int L  = 1 << m;
      localparam int WL = W_WIDTH / L;
      localparam int AL = A_WIDTH / L;
      logic signed [Z_WIDTH-1:0] lane_sum;

      always_comb begin : comb_lanes
         logic signed [WL-1:0]    wl;
         logic signed [AL:0]      al;
         logic signed [WL+AL:0]   prod;
         lane_sum = '0;
         wl       = '0;
         al       = '0;
         prod     = '0;
         for (int i = 0; i < L; i++) begin
            wl       = w_s1[i*WL +: WL];
            al       = {1'b0, a_s1[i*AL +: AL]};
            prod     = wl * al;
            lane_sum = lane_sum + Z_WIDTH'(prod);
         end
      end

      assign psum[m] = lane_sum;
   end

   // Stage 2: registered product sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_v     <= 1'b0;
         s2_first <= 1'b0;
         s2_last  <= 1'b0;
         p_s2     <= '0;
      end else begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_first <= s1_first;
            s2_last  <= s1_last;
            p_s2     <= psum[mode_q];
         end
      end
   end

   // Stage 3: two's-complement wrapping accumulate with signed-overflow detect.
   assign acc_base = s2_first ? '0 : acc;
   assign acc_sum  = acc_base + p_s2;
   assign add_ovf  = (acc_base[Z_WIDTH-1] == p_s2[Z_WIDTH-1]) &&
                     (acc_sum[Z_WIDTH-1]  != acc_base[Z_WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
         s3_last <= 1'b0;
      end else begin
         s3_last <= s2_v & s2_last;
         if (s2_v) begin
            acc     <= acc_sum;
            acc_ovf <= (s2_first ? 1'b0 : acc_ovf) | add_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         len_q     <= '0;
         mode_q    <= '0;
         z         <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mode_q <= mode_eff;
                  len_q  <= len_eff;
                  count  <= CNT_WIDTH'(1);
                  ovf    <= 1'b0;
                  state  <= acc_last ? DRAIN : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  count <= count + 1'b1;
                  if (acc_last) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (s3_last) begin
                  z         <= acc;
                  ovf       <= acc_ovf;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
